// File: rtl/serial_feeder_pkg.sv
// Shared definitions for the serial bit feeder: state encoding and default word width.
package serial_feeder_pkg;

   localparam logic [1:0] FEED_IDLE   = 2'd0;
   localparam logic [1:0] FEED_SHIFT  = 2'd1;
   localparam logic [1:0] FEED_PARITY = 2'd2;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = FEED_IDLE,
      ST_SHIFT  = FEED_SHIFT,
      ST_PARITY = FEED_PARITY
   } feed_state_t;

endpackage : serial_feeder_pkg

// File: rtl/serial_bit_feeder.sv
// Serial bit feeder: takes parallel words over valid/ready and emits them MSB-first,
// one bit per enabled clock, with a strobe and a word-boundary pulse.
// Optional feature macro: SERIAL_FEEDER_PARITY_EN appends an even-parity bit to every
// word (frame WIDTH+1 bits, one bubble cycle per word). Without it, words stream
// back-to-back with no gap.
module serial_bit_feeder
   import serial_feeder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             bit_en,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   feed_state_t      state_reg, state_next;
   logic [WIDTH-1:0] sreg_reg;
   logic [CW-1:0]    count_reg;
   logic             word_done_reg;
`ifdef SERIAL_FEEDER_PARITY_EN
   logic             parity_reg;
`endif

   logic accept;
   logic consume;
   logic last_data;
   logic frame_end;

   // The serial bit is always the shift register MSB, so it is a plain flop output.
   assign bit_out   = sreg_reg[WIDTH-1];
   assign bit_valid = (state_reg == ST_SHIFT) || (state_reg == ST_PARITY);
   assign busy      = (state_reg != ST_IDLE);
   assign word_done = word_done_reg;

   assign consume   = bit_valid && bit_en;
   assign last_data = consume && (state_reg == ST_SHIFT) && (count_reg == '0);
   assign accept    = in_valid && in_ready;

`ifdef SERIAL_FEEDER_PARITY_EN
   assign frame_end = consume && (state_reg == ST_PARITY);
`else
   assign frame_end = last_data;
`endif

   // Next-state selection and the ready handshake, both decoded from the current state.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (last_data) begin
`ifdef SERIAL_FEEDER_PARITY_EN
               state_next = ST_PARITY;
`else
               // Zero-bubble reload: the next word lands on the edge that eats the LSB.
               in_ready   = 1'b1;
               state_next = in_valid ? ST_SHIFT : ST_IDLE;
`endif
            end
         end
`ifdef SERIAL_FEEDER_PARITY_EN
         ST_PARITY: begin
            if (bit_en) state_next = ST_IDLE;
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   // State, shift register, bit counter and boundary pulse; a word in flight is dropped on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         sreg_reg      <= '0;
         count_reg     <= '0;
         word_done_reg <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
         parity_reg    <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         word_done_reg <= frame_end;
         if (accept) begin
            sreg_reg   <= in_data;
            count_reg  <= LAST_IDX;
`ifdef SERIAL_FEEDER_PARITY_EN
            parity_reg <= ^in_data;
`endif
         end else if (consume) begin
            if ((state_reg == ST_SHIFT) && (count_reg != '0)) begin
               sreg_reg  <= {sreg_reg[WIDTH-2:0], 1'b0};
               count_reg <= count_reg - 1'b1;
            end else if (state_reg == ST_SHIFT) begin
`ifdef SERIAL_FEEDER_PARITY_EN
               // Parity bit rides out through the same MSB flop as the data bits.
               sreg_reg <= {parity_reg, {(WIDTH-1){1'b0}}};
`else
               sreg_reg <= {sreg_reg[WIDTH-2:0], 1'b0};
`endif
            end else begin
               sreg_reg <= '0;
            end
         end
      end
   end

endmodule : serial_bit_feeder

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: directed words plus randomized traffic, with a queue-based
// model of the expected bit stream checked by an independent monitor.
module tb_serial_bit_feeder;

   localparam int WIDTH = 8;
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             bit_en;
   logic             bit_out;
   logic             bit_valid;
   logic             word_done;
   logic             busy;

   serial_bit_feeder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bit_en    (bit_en),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .word_done (word_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // One entry per serial bit still owed by the DUT.
   typedef struct packed {
      logic b;
      logic last;
      logic par;
   } exp_t;

   exp_t exp_q[$];
   int   vectors      = 0;
   int   miscompares  = 0;
   int   valid_cycles = 0;
   int   cyc          = 0;
   logic wd_exp       = 1'b0;
   int   en_mode      = 0;   // 0: bit_en=1, 1: toggle, 2: random

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: compares DUT outputs against the owed-bit queue every falling edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      logic exp_ready;
      logic nxt_wd;
      cyc++;
      if (reset) begin
         exp_q.delete();
         wd_exp = 1'b0;
      end else begin
         check("word_done", word_done, wd_exp);
         check("bit_valid", bit_valid, exp_q.size() != 0);
         check("busy", busy, exp_q.size() != 0);
         exp_ready = (exp_q.size() == 0) ||
                     (PAR == 0 && exp_q.size() == 1 && exp_q[0].last && bit_en);
         check("in_ready", in_ready, exp_ready);
         nxt_wd = 1'b0;
         if (exp_q.size() != 0) begin
            valid_cycles++;
            check("bit_out", bit_out, exp_q[0].b);
            if (bit_en) begin
               e = exp_q.pop_front();
               nxt_wd = e.last;
            end
         end
         wd_exp = nxt_wd;
      end
   end

   task automatic upd_en();
      case (en_mode)
         0:       bit_en = 1'b1;
         1:       bit_en = ~bit_en;
         default: bit_en = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1 upd_en();
      @(negedge clk);
      #1;
   endtask

   // Present a word, wait for the handshake, and record the bits it must produce.
   task automatic send_word(input logic [WIDTH-1:0] w, output int ready_at);
      int guard = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && guard < 500) begin
         tick();
         guard++;
      end
      check("accept_wait", guard < 500, 1);
      ready_at = valid_cycles;
      for (int i = WIDTH - 1; i >= 0; i--)
         exp_q.push_back('{b: w[i], last: (i == 0 && PAR == 0), par: 1'b0});
      if (PAR != 0)
         exp_q.push_back('{b: ^w, last: 1'b1, par: 1'b1});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      if (en_mode == 1) bit_en = 1'b1;
      else upd_en();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 1000) begin
         tick();
         guard++;
      end
      check("drain_wait", guard < 1000, 1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      int v0, c0, ra;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      bit_en   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_bit_valid", bit_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_word_done", word_done, 0);
      check("rst_bit_out", bit_out, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;

      // Single word, full-rate consumption.
      v0 = valid_cycles;
      send_word(8'hB5, ra);
      wait_idle();
      check("t1_bit_count", valid_cycles - v0, WIDTH + PAR);

      // Two words with in_valid held: back-to-back unless parity forces a bubble.
      v0 = valid_cycles;
      c0 = cyc;
      send_word(8'hB0, ra);
      send_word(8'h0F, ra);
      check("t2_ready_bit", ra - v0, WIDTH + PAR);
      wait_idle();
      check("t2_bit_count", valid_cycles - v0, 2 * (WIDTH + PAR));
      check("t2_span", cyc - c0, 2 * (WIDTH + PAR) + PAR);

      // Half-rate consumption: each bit holds through the disabled cycles.
      en_mode = 1;
      v0 = valid_cycles;
      send_word(8'hFF, ra);
      wait_idle();
      check("t3_valid_cycles", valid_cycles - v0, 2 * (WIDTH + PAR) - 1);
      en_mode = 0;
      bit_en  = 1'b1;
      tick();

      // Reset after the third bit of a word, then a clean word.
      send_word(8'hA5, ra);
      tick();
      tick();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("t4_async_valid", bit_valid, 0);
      check("t4_async_busy", busy, 0);
      check("t4_async_bit_out", bit_out, 0);
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      v0 = valid_cycles;
      send_word(8'h3C, ra);
      wait_idle();
      check("t4_bit_count", valid_cycles - v0, WIDTH + PAR);

      // Even-parity zero case.
      send_word(8'h33, ra);
      wait_idle();

      // Randomized traffic with random gaps and random bit_en.
      en_mode = 2;
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         send_word(WIDTH'($urandom), ra);
      end
      en_mode = 0;
      bit_en  = 1'b1;
      wait_idle();
      repeat (3) tick();
      check("final_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_serial_bit_feeder
